spi_master: RTL and testbench
=============================

# spi_master

Byte-wide SPI master that generates `sck`, `ssn` and `mosi` for the SPI slave stage and captures its `miso` reply. It sits upstream of the slave on the same link and uses the same control-byte layout (bit 2 = CPOL, bit 1 = CPHA), so both ends are configured from identical register values. Each transfer is one full-duplex 8-bit exchange, MSB first, started by a single-cycle request and closed by a one-cycle finish pulse.

## Interface
- `CLK_DIV`, default 4: system clocks per `sck` half-period. The legal minimum is 2. The counter width is `$clog2(CLK_DIV)`.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `data_m` in 8: transmit byte, latched on an accepted `start`.
- `spcon_m` in 8: control byte. [2] = CPOL, [1] = CPHA, [0] = SPE (enable). [7:3] are ignored.
- `start` in 1: transfer request. It is accepted only when `busy`=0 and SPE=1.
- `busy` out 1: high from the cycle after acceptance until the return to IDLE.
- `data_r_m` out 8: received byte. It updates only at the end of a transfer.
- `data_finish_m` out 1: one-cycle pulse when `data_r_m` is valid.
- `sck` out 1: SPI clock, registered.
- `ssn` out 1: slave select, active-low, registered.
- `mosi` out 1: serial data out, registered.
- `miso` in 1: serial data in.

## Operation
- **Reset values:** `sck`=0, `ssn`=1, `mosi`=0, `busy`=0, `data_finish_m`=0, `data_r_m`=0x00. The state is IDLE, and the shift register, edge counter and divider counter are all 0.
- **IDLE**
  - `ssn`=1, `mosi`=0, and `sck` <= `spcon_m[2]` every cycle.
  - When `start`=1 and SPE=1: latch `data_m` into `tx_sh`, latch CPOL and CPHA, set `ssn` <= 0 and `busy` <= 1, then go to SETUP.
  - If CPHA=0, also set `mosi` <= `data_m[7]`.
- **SETUP:** one half-period with `ssn` low and `sck` idle. Then go to SHIFT.
- **SHIFT:** 16 half-periods.
  - At the end of each half-period, `sck` toggles and the edge counter increments from 1 to 16.
  - Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: sample `miso` into `rx_sh` on leading edges. Drive the next `tx_sh` bit on trailing edges 2..14. Edge 16 drives nothing.
  - CPHA=1: drive `tx_sh` bit 7..0 on leading edges 1..15. Sample `miso` on trailing edges.
  - Sampling latches the `miso` value present at the `clk` edge that creates the sampling `sck` edge.
  - Shifting is MSB first: `rx_sh` <= {`rx_sh[6:0]`, `miso`}.
  - After edge 16, `sck` equals the latched CPOL. Go to HOLD.
- **HOLD:** one half-period with `ssn` low and `sck` idle.
  - At its end: `ssn` <= 1, `mosi` <= 0, `data_r_m` <= `rx_sh`, and `data_finish_m` <= 1 for exactly one cycle. Then go to GAP.
- **GAP:** one half-period with `ssn` high and `busy` still 1. Then go to IDLE, where `busy` <= 0.
- **Boundary rules:**
  - `start` while `busy`=1 is ignored, with no queuing.
  - `start` with SPE=0 is ignored.
  - Changes to `data_m` or `spcon_m` during a transfer have no effect.
  - Clearing SPE mid-transfer does not abort the transfer.
  - `rst` asserted in any state forces the reset values immediately, with no wait for `clk`. No `data_finish_m` pulse is produced and `data_r_m` clears to 0x00.

## Timing
- Take C as the `clk` edge that accepts `start`.
  - `ssn` falls and `busy` rises at C+1.
  - `sck` edge k occurs at C+1+(k+1)·CLK_DIV, for k=1..16.
- `ssn` stays low for exactly 18·CLK_DIV cycles.
- `data_finish_m` is high in the single cycle in which `ssn` returns high. `data_r_m` is stable from that cycle on.
- `busy` falls CLK_DIV cycles after `ssn` rises. `busy` is high for 19·CLK_DIV cycles in total.
- The earliest next accepted `start` is the cycle in which `busy`=0 is first observed.
- The `sck` duty cycle is exactly 50%, with period 2·CLK_DIV.
- In CPHA=0, `mosi` is valid a full half-period before every leading edge.

## Test plan
- **Mode 0 loopback:** CLK_DIV=4, `spcon_m`=0x01, `miso` tied to `mosi`, `data_m`=0xA5, `start` pulse.
  - Required: 8 rising `sck` edges, `ssn` low for 72 cycles, `data_r_m`=0xA5, `data_finish_m` high for 1 cycle.
- **Mode 3 against the SPI slave model:** `spcon_m`=0x07, slave `spcon_s`=0x06, slave transmit byte 0x3C, master `data_m`=0xC3.
  - Required: master `data_r_m`=0x3C, slave receive register=0xC3, `sck` idle high before and after the transfer.
- **Start while busy:** second `start` 10 cycles after the first.
  - Required: exactly one transfer occurs (16 `sck` edges), one finish pulse, and `busy` stays high for 76 cycles.
- **SPE=0:** `start` with `spcon_m`=0x00.
  - Required: `ssn` stays 1, `busy` stays 0, no `sck` toggle, no finish pulse.
- **Reset mid-transfer:** assert `rst` after `sck` edge 7, mid-cycle.
  - Required: `ssn`=1, `sck`=0, `busy`=0 and `data_r_m`=0x00 before the next `clk` edge, and no finish pulse.
  - After release, a new 0x5A transfer completes correctly.
- **CLK_DIV=2:**
  - Required: `sck` period of 4 cycles, `ssn` low for 36 cycles, back-to-back transfers with `start` asserted in the first `busy`=0 cycle both complete.

Source files
------------

// File: rtl/spi_master_if.sv
// Bus bundle between the SPI master and whatever drives/observes it.
// The master modport is the DUT view; the slave modport is the opposite side
// (host logic plus the serial link partner).
interface spi_master_if;
   logic [7:0] data_m;
   logic [7:0] spcon_m;
   logic       start;
   logic       busy;
   logic [7:0] data_r_m;
   logic       data_finish_m;
   logic       sck;
   logic       ssn;
   logic       mosi;
   logic       miso;

   modport master (
      input  data_m, spcon_m, start, miso,
      output busy, data_r_m, data_finish_m, sck, ssn, mosi
   );

   modport slave (
      output data_m, spcon_m, start, miso,
      input  busy, data_r_m, data_finish_m, sck, ssn, mosi
   );
endinterface

// File: rtl/spi_master.sv
// Byte-wide full-duplex SPI master, MSB first, CPOL/CPHA from spcon_m[2:1].
// Sequence per transfer: SETUP (ssn low, sck idle), SHIFT (16 sck edges),
// HOLD (ssn low, sck idle), GAP (ssn high, still busy). Each phase lasts a
// whole number of sck half-periods of CLK_DIV system clocks.
module spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         rst,
   spi_master_if.master bus
);

   localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] div_q, div_d;
   logic [4:0]    edge_q, edge_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic          cpol_q, cpol_d;
   logic          cpha_q, cpha_d;
   logic          sck_q, sck_d;
   logic          ssn_q, ssn_d;
   logic          mosi_q, mosi_d;
   logic          busy_q, busy_d;
   logic [7:0]    data_r_q, data_r_d;
   logic          fin_q, fin_d;

   logic          half_end;
   logic [4:0]    next_edge;

   assign half_end  = (div_q == DIV_LAST);
   assign next_edge = edge_q + 5'd1;

   assign bus.sck           = sck_q;
   assign bus.ssn           = ssn_q;
   assign bus.mosi          = mosi_q;
   assign bus.busy          = busy_q;
   assign bus.data_r_m      = data_r_q;
   assign bus.data_finish_m = fin_q;

   // State and datapath registers; reset is asynchronous so outputs go idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         edge_q   <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         sck_q    <= 1'b0;
         ssn_q    <= 1'b1;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         data_r_q <= '0;
         fin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         edge_q   <= edge_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         sck_q    <= sck_d;
         ssn_q    <= ssn_d;
         mosi_q   <= mosi_d;
         busy_q   <= busy_d;
         data_r_q <= data_r_d;
         fin_q    <= fin_d;
      end
   end

   // Next-state and output logic; every phase advances on the last divider tick.
   always_comb begin
      state_d  = state_q;
      div_d    = half_end ? '0 : div_q + CW'(1);
      edge_d   = edge_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      sck_d    = sck_q;
      ssn_d    = ssn_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      data_r_d = data_r_q;
      fin_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            div_d  = '0;
            edge_d = '0;
            ssn_d  = 1'b1;
            mosi_d = 1'b0;
            sck_d  = bus.spcon_m[2];
            if (bus.start && bus.spcon_m[0]) begin
               tx_d    = bus.data_m;
               rx_d    = '0;
               cpol_d  = bus.spcon_m[2];
               cpha_d  = bus.spcon_m[1];
               ssn_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_SETUP;
               // CPHA=0 needs the first bit on the wire before the first leading edge.
               if (!bus.spcon_m[1]) begin
                  mosi_d = bus.data_m[7];
               end
            end
         end

         S_SETUP: begin
            if (half_end) begin
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (half_end) begin
               sck_d  = ~sck_q;
               edge_d = next_edge;
               if (next_edge[0]) begin
                  // Leading edge: sample for CPHA=0, drive for CPHA=1.
                  if (!cpha_q) begin
                     rx_d = {rx_q[6:0], bus.miso};
                  end else begin
                     mosi_d = tx_q[7];
                     tx_d   = {tx_q[6:0], 1'b0};
                  end
               end else begin
                  // Trailing edge: drive the next bit for CPHA=0 (none after the last), sample for CPHA=1.
                  if (!cpha_q) begin
                     if (next_edge != 5'd16) begin
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[6:0], 1'b0};
                     end
                  end else begin
                     rx_d = {rx_q[6:0], bus.miso};
                  end
               end
               if (next_edge == 5'd16) begin
                  state_d = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (half_end) begin
               ssn_d    = 1'b1;
               mosi_d   = 1'b0;
               data_r_d = rx_q;
               fin_d    = 1'b1;
               state_d  = S_GAP;
            end
         end

         S_GAP: begin
            if (half_end) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=2) sharing the
// stimulus, a behavioural SPI slave on the link, directed vectors, random
// transfers and hand-written corner sequences.
module tb_spi_master;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spi_master_if bus4 ();
   spi_master_if bus2 ();

   spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Stimulus variables and DUT selection.
   logic       sel_v   = 1'b0;
   logic       loop_v  = 1'b0;
   logic       start_v = 1'b0;
   logic [7:0] data_v  = 8'h00;
   logic [7:0] spcon_v = 8'h00;

   // Slave model state.
   logic [7:0] s_byte = 8'h00;
   logic       s_cpol = 1'b0;
   logic       s_cpha = 1'b0;
   logic [7:0] s_sh   = 8'h00;
   logic [7:0] s_rx   = 8'h00;
   logic       s_miso = 1'b0;
   logic       s_prev_sck = 1'b0;
   logic       s_prev_ssn = 1'b1;

   logic       obs_sck, obs_ssn, obs_mosi, obs_busy, obs_fin;
   logic [7:0] obs_data_r;
   logic       miso_in;

   int n_tests = 0;
   int n_fail  = 0;

   assign bus4.data_m  = data_v;
   assign bus2.data_m  = data_v;
   assign bus4.spcon_m = spcon_v;
   assign bus2.spcon_m = spcon_v;
   assign bus4.start   = start_v & ~sel_v;
   assign bus2.start   = start_v & sel_v;

   assign obs_sck    = sel_v ? bus2.sck           : bus4.sck;
   assign obs_ssn    = sel_v ? bus2.ssn           : bus4.ssn;
   assign obs_mosi   = sel_v ? bus2.mosi          : bus4.mosi;
   assign obs_busy   = sel_v ? bus2.busy          : bus4.busy;
   assign obs_fin    = sel_v ? bus2.data_finish_m : bus4.data_finish_m;
   assign obs_data_r = sel_v ? bus2.data_r_m      : bus4.data_r_m;

   assign miso_in   = loop_v ? obs_mosi : s_miso;
   assign bus4.miso = miso_in;
   assign bus2.miso = miso_in;

   // Behavioural SPI slave: watches the link on falling clk edges, shifts MSB first.
   always @(negedge clk) begin
      s_prev_ssn <= obs_ssn;
      if (obs_ssn) begin
         s_prev_sck <= obs_sck;
      end else if (s_prev_ssn) begin
         s_sh       <= s_byte;
         s_miso     <= s_byte[7];
         s_prev_sck <= obs_sck;
      end else if (obs_sck != s_prev_sck) begin
         s_prev_sck <= obs_sck;
         if (!s_cpha) begin
            if (obs_sck != s_cpol) begin
               s_rx <= {s_rx[6:0], obs_mosi};
            end else begin
               s_sh   <= {s_sh[6:0], 1'b0};
               s_miso <= s_sh[6];
            end
         end else begin
            if (obs_sck != s_cpol) begin
               s_miso <= s_sh[7];
               s_sh   <= {s_sh[6:0], 1'b0};
            end else begin
               s_rx <= {s_rx[6:0], obs_mosi};
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One transfer with timing measured against the closed-form schedule.
   task automatic run_xfer(input logic sel, input logic [7:0] ctl, input logic [7:0] data,
                           input logic [7:0] sbyte, input logic loop, input logic [7:0] exp_r,
                           input bit pre, input int restart_at, input bit post);
      int d, n, busy_cnt, ssn_cnt, edges, edge_bad, fin_cnt, fin_n, quiet_bad;
      logic prev, sck_end;
      logic [7:0] got_r;
      d = sel ? 2 : 4;
      busy_cnt = 0; ssn_cnt = 0; edges = 0; edge_bad = 0; fin_cnt = 0; fin_n = -1;
      got_r = 8'h00; sck_end = ~ctl[2];
      sel_v = sel; loop_v = loop; s_byte = sbyte; s_cpol = ctl[2]; s_cpha = ctl[1];
      data_v = data; spcon_v = ctl;
      if (pre) begin
         repeat (2) @(negedge clk);
         chk("idle_sck_before", int'(obs_sck), int'(ctl[2]));
      end
      start_v = 1'b1;
      @(negedge clk);
      start_v = 1'b0;
      // Inputs wander during the transfer; the latched copies must be used.
      data_v  = 8'($urandom);
      spcon_v = 8'($urandom);
      prev = ctl[2];
      n = 1;
      while (n <= 40 * d) begin
         if (obs_busy) busy_cnt++;
         if (!obs_ssn) ssn_cnt++;
         if (obs_sck != prev) begin
            edges++;
            if (n != 1 + (edges + 1) * d) edge_bad++;
            prev = obs_sck;
         end
         if (obs_fin) begin
            fin_cnt++;
            fin_n = n;
            got_r = obs_data_r;
         end
         if (n == 18 * d + 1) sck_end = obs_sck;
         if (!obs_busy) break;
         start_v = (n == restart_at);
         @(negedge clk);
         n++;
      end
      start_v = 1'b0;
      data_v  = data;
      spcon_v = ctl;
      chk("busy_cycles", busy_cnt, 19 * d);
      chk("ssn_low_cycles", ssn_cnt, 18 * d);
      chk("sck_edges", edges, 16);
      chk("sck_edge_timing_errors", edge_bad, 0);
      chk("finish_pulses", fin_cnt, 1);
      chk("finish_cycle", fin_n, 18 * d + 1);
      chk("data_r_at_finish", int'(got_r), int'(exp_r));
      chk("data_r_held", int'(obs_data_r), int'(exp_r));
      chk("slave_rx", int'(s_rx), int'(data));
      chk("sck_idle_after", int'(sck_end), int'(ctl[2]));
      $display("[TB] xfer div=%0d ctl=%02h tx=%02h rx=%02h exp=%02h slave_rx=%02h loop=%0d",
               d, ctl, data, got_r, exp_r, s_rx, loop);
      if (post) begin
         quiet_bad = 0;
         repeat (2 * d) begin
            @(negedge clk);
            if (!obs_ssn || obs_busy || obs_fin) quiet_bad++;
         end
         chk("quiet_after", quiet_bad, 0);
      end
   endtask

   typedef struct {
      logic       sel;
      logic [7:0] ctl;
      logic [7:0] data;
      logic [7:0] sbyte;
      logic       loop;
      logic [7:0] exp_r;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges, n, cnt_ssn, cnt_busy, cnt_tog, cnt_fin, fins;
      logic prev, sel_r, loop_r;
      logic [7:0] r_ctl, r_data, r_sb;

      tbl[0] = '{1'b0, 8'h01, 8'hA5, 8'h00, 1'b1, 8'hA5};   // mode 0 loopback
      tbl[1] = '{1'b0, 8'h07, 8'hC3, 8'h3C, 1'b0, 8'h3C};   // mode 3 against slave
      tbl[2] = '{1'b0, 8'h03, 8'h81, 8'h7E, 1'b0, 8'h7E};   // mode 1
      tbl[3] = '{1'b0, 8'h05, 8'h0F, 8'hF0, 1'b0, 8'hF0};   // mode 2
      tbl[4] = '{1'b1, 8'h01, 8'h96, 8'h69, 1'b0, 8'h69};   // CLK_DIV=2 mode 0
      tbl[5] = '{1'b1, 8'hFF, 8'h12, 8'hED, 1'b0, 8'hED};   // upper control bits ignored

      // Reset values.
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_sck", int'(obs_sck), 0);
      chk("reset_ssn", int'(obs_ssn), 1);
      chk("reset_mosi", int'(obs_mosi), 0);
      chk("reset_busy", int'(obs_busy), 0);
      chk("reset_finish", int'(obs_fin), 0);
      chk("reset_data_r", int'(obs_data_r), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_xfer(tbl[i].sel, tbl[i].ctl, tbl[i].data, tbl[i].sbyte, tbl[i].loop,
                  tbl[i].exp_r, 1'b1, 0, 1'b1);
      end

      // Second start 10 cycles into a transfer is ignored.
      run_xfer(1'b0, 8'h01, 8'h3D, 8'hB2, 1'b0, 8'hB2, 1'b1, 10, 1'b1);

      // Asynchronous reset right after sck edge 7.
      sel_v = 1'b0; loop_v = 1'b0; s_byte = 8'h6D; s_cpol = 1'b0; s_cpha = 1'b1;
      data_v = 8'h33; spcon_v = 8'h03;
      repeat (2) @(negedge clk);
      start_v = 1'b1;
      @(negedge clk);
      start_v = 1'b0;
      edges = 0; n = 0; prev = 1'b0;
      while (edges < 7 && n < 400) begin
         @(negedge clk);
         n++;
         if (obs_sck != prev) begin
            edges++;
            prev = obs_sck;
         end
      end
      chk("rst_reached_edge7", edges, 7);
      chk("rst_prior_data_r", int'(obs_data_r), 8'hB2);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_ssn", int'(obs_ssn), 1);
      chk("rst_async_sck", int'(obs_sck), 0);
      chk("rst_async_busy", int'(obs_busy), 0);
      chk("rst_async_data_r", int'(obs_data_r), 0);
      fins = 0;
      repeat (3) begin
         @(negedge clk);
         fins += int'(obs_fin);
      end
      rst = 1'b0;
      repeat (4 * 4) begin
         @(negedge clk);
         fins += int'(obs_fin);
      end
      chk("rst_no_finish", fins, 0);
      run_xfer(1'b0, 8'h03, 8'h5A, 8'h99, 1'b0, 8'h99, 1'b1, 0, 1'b1);

      // start with SPE=0 does nothing; idle sck still follows CPOL.
      sel_v = 1'b0; spcon_v = 8'h06;
      repeat (2) @(negedge clk);
      prev = obs_sck;
      chk("spe0_idle_sck", int'(obs_sck), 1);
      cnt_ssn = 0; cnt_busy = 0; cnt_tog = 0; cnt_fin = 0;
      start_v = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 2) start_v = 1'b0;
         if (!obs_ssn) cnt_ssn++;
         if (obs_busy) cnt_busy++;
         if (obs_fin) cnt_fin++;
         if (obs_sck != prev) begin
            cnt_tog++;
            prev = obs_sck;
         end
      end
      start_v = 1'b0;
      chk("spe0_ssn_low", cnt_ssn, 0);
      chk("spe0_busy", cnt_busy, 0);
      chk("spe0_sck_toggles", cnt_tog, 0);
      chk("spe0_finish", cnt_fin, 0);
      $display("[TB] spe0 start: ssn_low=%0d busy=%0d toggles=%0d finish=%0d",
               cnt_ssn, cnt_busy, cnt_tog, cnt_fin);

      // Random transfers against the slave model (or loopback).
      for (int i = 0; i < 12; i++) begin
         sel_r  = 1'($urandom_range(0, 1));
         loop_r = 1'($urandom_range(0, 1));
         r_ctl  = 8'($urandom) | 8'h01;
         r_data = 8'($urandom);
         r_sb   = 8'($urandom);
         run_xfer(sel_r, r_ctl, r_data, r_sb, loop_r, loop_r ? r_data : r_sb,
                  1'b1, 0, 1'b1);
      end

      // Back-to-back at CLK_DIV=2: second start in the first busy=0 cycle.
      run_xfer(1'b1, 8'h01, 8'h11, 8'h22, 1'b0, 8'h22, 1'b1, 0, 1'b0);
      run_xfer(1'b1, 8'h03, 8'hEE, 8'h44, 1'b0, 8'h44, 1'b0, 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
